// File: rtl/pipe_hazard_sb.sv
// pipe_hazard_sb: ID-stage hazard detection and operand forwarding for the pipelined CPU.
// A shift-register scoreboard tracks in-flight register writers at ages 1 (EXE) .. DEPTH (WB).
// Each entry records the age at which its result becomes forwardable (rdy).
// Optional feature: define HZ_PERF_CNT_EN to build the saturating stall-cycle counter
// behind stall_cnt. Without it, stall_cnt is tied to zero.
module pipe_hazard_sb #(
    parameter int unsigned RW      = 5,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned MUL_LAT = 2,
    localparam int unsigned FW     = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wreg,
    input  logic [RW-1:0] id_wn,
    input  logic [1:0]    id_lat,
    input  logic          flush,
    output logic          stall,
    output logic          issue,
    output logic [FW-1:0] fwd_a,
    output logic [FW-1:0] fwd_b,
    output logic [31:0]   stall_cnt
);

    // Scoreboard, index = age after ID
    logic [DEPTH:1] valid_q;
    logic [RW-1:0]  rn_q  [DEPTH:1];
    logic [FW-1:0]  rdy_q [DEPTH:1];

    logic [FW-1:0] rdy_in;
    logic          hit_a, hit_b;
    logic [FW-1:0] age_a, age_b;
    logic [FW-1:0] rdy_a, rdy_b;
    logic          track_a, track_b;
    logic          hazard_a, hazard_b;
    logic          new_valid;

    // Ready age of the ID instruction's result, by latency class
    always_comb begin
        rdy_in = FW'(DEPTH);
        case (id_lat)
            2'd0:    rdy_in = FW'(1);
            2'd1:    rdy_in = FW'(2);
            2'd2:    rdy_in = FW'(MUL_LAT);
            default: rdy_in = FW'(DEPTH);
        endcase
    end

    // Source lookup: scan oldest to youngest so the youngest match overwrites
    always_comb begin
        hit_a = 1'b0;
        age_a = '0;
        rdy_a = '0;
        hit_b = 1'b0;
        age_b = '0;
        rdy_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (valid_q[k] && (rn_q[k] == id_rs)) begin
                hit_a = 1'b1;
                age_a = FW'(k);
                rdy_a = rdy_q[k];
            end
            if (valid_q[k] && (rn_q[k] == id_rt)) begin
                hit_b = 1'b1;
                age_b = FW'(k);
                rdy_b = rdy_q[k];
            end
        end
    end

    // Hazard, forward select, stall and issue decisions
    always_comb begin
        track_a   = id_use_rs && (id_rs != '0);
        track_b   = id_use_rt && (id_rt != '0);
        hazard_a  = track_a && hit_a && (age_a < rdy_a);
        hazard_b  = track_b && hit_b && (age_b < rdy_b);
        fwd_a     = (track_a && hit_a && !hazard_a) ? age_a : '0;
        fwd_b     = (track_b && hit_b && !hazard_b) ? age_b : '0;
        // Flush wins over a hazard: a squashed instruction never stalls
        stall     = id_valid && !flush && (hazard_a || hazard_b);
        issue     = id_valid && !flush && !stall;
        new_valid = issue && id_wreg && (id_wn != '0);
    end

    // Scoreboard shifts every cycle; a stalled or flushed slot enters as a bubble
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                rn_q[k]  <= '0;
                rdy_q[k] <= '0;
            end
        end else begin
            valid_q[1] <= new_valid;
            rn_q[1]    <= id_wn;
            rdy_q[1]   <= rdy_in;
            for (int k = 2; k <= DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
                rn_q[k]    <= rn_q[k-1];
                rdy_q[k]   <= rdy_q[k-1];
            end
        end
    end

`ifdef HZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_hazard_sb.md
# pipe_hazard_sb

Parametrised hazard-detection and forwarding scoreboard for the pipelined CPU's ID stage. It replaces fixed EXE/MEM compare logic with a shift-register scoreboard of in-flight register writers, `DEPTH` stages deep. Each writer carries a latency class (ALU, load, multi-cycle multiply). Every cycle the block produces per-operand forwarding selects and a stall for the ID stage, and drops squashed instructions on a branch flush.

## Interface
Parameters:
- `RW`, 5 — register-number width.
- `DEPTH`, 3 — tracked stages after ID (age 1 = EXE … age `DEPTH` = WB); legal 2..7.
- `MUL_LAT`, 2 — age at which a multiply result becomes forwardable; legal 1..`DEPTH`.
- `FW` (localparam) = `$clog2(DEPTH+1)` — width of the forward selects.

Ports:
- `clock` in 1 — rising-edge clock.
- `resetn` in 1 — asynchronous, active-low reset.
- `id_valid` in 1 — ID holds a real instruction.
- `id_rs`, `id_rt` in `RW` — source register numbers.
- `id_use_rs`, `id_use_rt` in 1 — the source is actually read (this includes ID-resolved branch compares).
- `id_wreg` in 1 — the instruction writes a register.
- `id_wn` in `RW` — destination register.
- `id_lat` in 2 — latency class: 0 ALU, 1 load, 2 mul, 3 WB-only.
- `flush` in 1 — squash the instruction in ID this cycle (taken branch/jump).
- `stall` out 1 — hold PC and IF/ID, insert a bubble into EXE.
- `issue` out 1 — the ID instruction advances this cycle.
- `fwd_a`, `fwd_b` out `FW` — operand source: 0 = register file, k = result at age k.
- `stall_cnt` out 32 — stall-cycle counter (only with `HZ_PERF_CNT_EN`).

## Operation
- Scoreboard entries 1..`DEPTH` each hold {valid, rn, rdy}.
  - `rdy` by latency class: ALU → 1, load → 2, mul → `MUL_LAT`, class 3 → `DEPTH`.
- Source lookup:
  - A source s is tracked only if its use flag is set and s ≠ 0.
  - Find the smallest age k with valid & rn == s. The youngest match wins.
  - No match → fwd = 0, no hazard.
  - k ≥ rdy[k] → fwd = k.
  - k < rdy[k] → hazard; fwd = 0.
- `stall` = `id_valid` & ~`flush` & (hazard_a | hazard_b).
- `issue` = `id_valid` & ~`flush` & ~`stall`.
- Shift at every rising edge, regardless of stall:
  - Entry k moves to k+1.
  - Entry `DEPTH` retires. The register file is written that cycle, so age `DEPTH` is still forwardable.
  - Entry 1 loads {`issue` & `id_wreg` & (`id_wn` ≠ 0), `id_wn`, rdy(`id_lat`)}. Otherwise entry 1 becomes a bubble (valid = 0).
- On `flush`, the ID instruction never enters the scoreboard. Older entries are unaffected.
- Simultaneous `flush` and hazard: `flush` wins, so `stall` = 0.
- Same destination at several ages: only the youngest entry matters for lookup; older entries still retire normally.

## Timing
- `stall`, `issue`, `fwd_a`, `fwd_b` are combinational from the registered scoreboard plus the current ID inputs. There is no added latency.
- The scoreboard updates at the rising edge of `clock`.
- A load followed immediately by a consumer gives exactly 1 stall cycle. A multiply gives `MUL_LAT`−1 stall cycles.
- Reset (`resetn` low, any time, including mid-stall): all entries invalid immediately, `stall_cnt` = 0. Outputs then follow the inputs with an empty scoreboard: `stall` = 0, `fwd_a` = `fwd_b` = 0, `issue` = `id_valid` & ~`flush`.
- Operation resumes on the first rising edge after `resetn` is released.

## Configuration
- `HZ_PERF_CNT_EN` defined:
  - `stall_cnt` increments on each cycle with `stall` = 1.
  - It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- `HZ_PERF_CNT_EN` not defined:
  - The counter register is not built and `stall_cnt` is tied to 0.
  - Every other behaviour is identical.

## Test plan
Defaults are `DEPTH`=3, `MUL_LAT`=2 unless stated.
- ALU back-to-back: issue add → r3 (lat 0); next cycle ID reads rs = 3 → `stall` = 0, `fwd_a` = 1; the cycle after, the same read gives `fwd_a` = 2.
- Load-use: issue lw → r4 (lat 1); next ID reads rt = 4 → `stall` = 1 for one cycle, then `fwd_b` = 2, `issue` = 1, `stall_cnt` = 1.
- Youngest priority: add → r5, then addi → r5, then a read of rs = 5 → `fwd_a` = 1, not 2.
- r0 and flush:
  - A write to r0 followed by a read of rs = 0 → `fwd_a` = 0, `stall` = 0.
  - lw → r6 with `flush` = 1, then a read of r6 → `stall` = 0, `fwd` = 0.
- Multiply, `DEPTH`=4, `MUL_LAT`=3: mul → r7, then a consumer of r7 → `stall` for 2 cycles, then `fwd_a` = 3. A consumer that arrives with `flush` = 1 during the stall → `stall` = 0.
- Reset mid-operation: lw → r4 in flight, consumer stalled; pulse `resetn` low between edges → `stall` drops immediately, `fwd_b` = 0, `stall_cnt` = 0. After release the scoreboard is empty.
